jtag_tap_ctrl: RTL
==================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_LEN, default 4: instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1180_0001: device ID; bit 0 SHALL be 1.
REQ-003 SHALL have port tck_i, in, 1: the block's only clock; all flops on the rising edge.
REQ-004 SHALL have port trst_i, in, 1: reset, synchronous and active-high.
REQ-005 SHALL have port tms_i, in, 1: test mode select.
REQ-006 SHALL have port tdi_i, in, 1: test data in.
REQ-007 SHALL have ports debug_tdi_i, bs_chain_tdi_i and mbist_tdi_i, in, 1 each: serial returns from the downstream test data registers.
REQ-008 SHALL have port tdo_o, out, 1: serial out.
REQ-009 SHALL have port tdo_oe_o, out, 1: high only in SHIFT_IR and SHIFT_DR.
REQ-010 SHALL have port test_logic_reset_o, out, 1: high in TEST_LOGIC_RESET.
REQ-011 SHALL have ports capture_dr_o, shift_dr_o, pause_dr_o and update_dr_o, out, 1 each: DR state strobes.
REQ-012 SHALL have ports extest_select_o, sample_preload_select_o, mbist_select_o and debug_select_o, out, 1 each: instruction decodes.

Function
REQ-013 SHALL implement the 16-state IEEE 1149.1 TAP FSM, with transitions on tms_i at each rising edge of tck_i.
REQ-014 SHALL decode every DR/TLR strobe combinationally from the registered state, so each strobe is high for exactly the cycles spent in its state.
REQ-015 Downstream registers sample on the edge that leaves a state, so SHALL NOT register the strobes.
REQ-016 SHALL use IR shift register ir_sr[IR_LEN-1:0] in CAPTURE_IR: load 4'b0101.
REQ-017 SHALL use ir_sr in SHIFT_IR: ir_sr <= {tdi_i, ir_sr[IR_LEN-1:1]}.
REQ-018 SHALL, in UPDATE_IR, copy ir_sr to ir_reg.
REQ-019 SHALL, in TEST_LOGIC_RESET, load ir_reg = IDCODE (4'b0010).
REQ-020 SHALL use opcodes EXTEST 4'b0000, SAMPLE_PRELOAD 4'b0001, IDCODE 4'b0010, MBIST 4'b0100, DEBUG 4'b1000, and BYPASS 4'b1111 plus every other value.
REQ-021 SHALL decode the select outputs from ir_reg only, so selects change only on the edge leaving UPDATE_IR or on entering TEST_LOGIC_RESET.
REQ-022 SHALL use a 1-bit bypass register: load 0 in CAPTURE_DR when BYPASS is active, and load tdi_i in SHIFT_DR.
REQ-023 SHALL use a 32-bit IDCODE register: load IDCODE_VALUE in CAPTURE_DR when IDCODE is active, and shift right, LSB first, from tdi_i in SHIFT_DR.
REQ-024 SHALL drive tdo_o combinationally as follows: SHIFT_IR -> ir_sr[0]; SHIFT_DR -> the selected DR bit 0.
REQ-025 The selected DR bit 0 SHALL be bs_chain_tdi_i for EXTEST/SAMPLE_PRELOAD, mbist_tdi_i for MBIST, debug_tdi_i for DEBUG, the IDCODE register bit 0 for IDCODE, and the bypass bit otherwise.
REQ-026 SHALL drive tdo_o = 0 outside the shift states.
REQ-027 SHALL NOT alter ir_reg or the selects by any DR-path activity.
REQ-028 SHALL reach TEST_LOGIC_RESET from any state after 5 consecutive tms_i=1 cycles.
REQ-029 SHALL hold state, ir_sr and the DR contents in PAUSE_IR/PAUSE_DR regardless of tdi_i.

Reset
REQ-030 SHALL, when trst_i=1 at a rising edge, set state=TEST_LOGIC_RESET, ir_reg=IDCODE (or BYPASS without JTAG_IDCODE_EN), ir_sr=0, bypass=0 and the IDCODE shift register=0.
REQ-031 trst_i SHALL override tms_i and take effect even mid-shift.
REQ-032 SHALL produce these output values during and after reset: test_logic_reset_o=1, all DR strobes=0, all selects=0, tdo_oe_o=0, tdo_o=0.

Configuration
REQ-033 SHALL, when macro JTAG_IDCODE_EN is defined, compile in the 32-bit IDCODE register with the IDCODE opcode selecting it.
REQ-034 SHALL make IDCODE the reset instruction when JTAG_IDCODE_EN is defined.
REQ-035 SHALL, when JTAG_IDCODE_EN is undefined, omit the IDCODE register, decode 4'b0010 as BYPASS, and make BYPASS the reset instruction.

Verification
REQ-036 Bench SHALL cover this scenario: from every one of the 16 states, 5x tms=1 -> state TEST_LOGIC_RESET and test_logic_reset_o=1.
REQ-037 Bench SHALL cover this scenario: after reset, go to SHIFT_DR and shift 32 bits -> tdo_o sequence equals 32'h1180_0001 LSB first; with JTAG_IDCODE_EN undefined -> first bit 0, then tdi delayed by one cycle.
REQ-038 Bench SHALL cover this scenario: go to SHIFT_IR, shift in 4'b0001 -> tdo_o emits 1,0,1,0; after UPDATE_IR, sample_preload_select_o=1 and the others=0.
REQ-039 Bench SHALL cover this scenario: BYPASS loaded, shift tdi pattern 1,1,0,1 in SHIFT_DR -> tdo_o emits 0,1,1,0.
REQ-040 Bench SHALL cover this scenario: DEBUG loaded, trace CAPTURE_DR, 3xSHIFT_DR, EXIT1, PAUSE, EXIT2, UPDATE -> capture/shift/pause/update strobes high exactly 1/3/1/1 cycles; tdo_o follows debug_tdi_i only in SHIFT_DR.
REQ-041 Bench SHALL cover this scenario: trst_i=1 for one cycle during SHIFT_IR with EXTEST loaded -> next cycle state is TEST_LOGIC_RESET, extest_select_o=0, and ir_reg is the reset instruction.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, bypass and DR strobes.
// Optional feature macro JTAG_IDCODE_EN adds the 32-bit IDCODE register and makes IDCODE the reset instruction.
module jtag_tap_ctrl #(
  parameter int          IR_LEN       = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1180_0001
) (
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic debug_tdi_i,
  input  logic bs_chain_tdi_i,
  input  logic mbist_tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic extest_select_o,
  output logic sample_preload_select_o,
  output logic mbist_select_o,
  output logic debug_select_o
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_LEN-1:0] OP_EXTEST  = IR_LEN'(4'b0000);
  localparam logic [IR_LEN-1:0] OP_SAMPLE  = IR_LEN'(4'b0001);
  localparam logic [IR_LEN-1:0] OP_MBIST   = IR_LEN'(4'b0100);
  localparam logic [IR_LEN-1:0] OP_DEBUG   = IR_LEN'(4'b1000);
  localparam logic [IR_LEN-1:0] OP_BYPASS  = '1;
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'b0101);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_LEN-1:0] OP_IDCODE  = IR_LEN'(4'b0010);
  localparam logic [IR_LEN-1:0] RST_INSTR  = OP_IDCODE;
`else
  localparam logic [IR_LEN-1:0] RST_INSTR  = OP_BYPASS;
`endif

  // A 1149.1 IDCODE must end in 1 so a chain scan can tell it apart from a bypass bit.
  if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE_VALUE bit 0 must be 1");
  end

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_sr_q, ir_sr_d;
  logic [IR_LEN-1:0] ir_reg_q, ir_reg_d;
  logic              bypass_q, bypass_d;
`ifdef JTAG_IDCODE_EN
  logic [31:0]       idcode_sr_q, idcode_sr_d;
`endif

  logic sel_extest, sel_sample, sel_mbist, sel_debug, sel_idcode, sel_bypass;
  logic dr_bit;

  assign sel_extest = (ir_reg_q == OP_EXTEST);
  assign sel_sample = (ir_reg_q == OP_SAMPLE);
  assign sel_mbist  = (ir_reg_q == OP_MBIST);
  assign sel_debug  = (ir_reg_q == OP_DEBUG);
`ifdef JTAG_IDCODE_EN
  assign sel_idcode = (ir_reg_q == OP_IDCODE);
`else
  assign sel_idcode = 1'b0;
`endif
  assign sel_bypass = !(sel_extest || sel_sample || sel_mbist || sel_debug || sel_idcode);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms_i ? TLR    : RTI;
      RTI:    state_d = tms_i ? SEL_DR : RTI;
      SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms_i ? SEL_DR : RTI;
      SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms_i ? SEL_DR : RTI;
    endcase
  end

  // ir_reg is reloaded on the edge that enters TLR so the selects drop together with the state change.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_reg_d = ir_reg_q;
    bypass_d = bypass_q;
    if (state_q == CAP_IR)     ir_sr_d = IR_CAPTURE;
    else if (state_q == SH_IR) ir_sr_d = {tdi_i, ir_sr_q[IR_LEN-1:1]};
    if (state_d == TLR)         ir_reg_d = RST_INSTR;
    else if (state_q == UPD_IR) ir_reg_d = ir_sr_q;
    if (state_q == CAP_DR && sel_bypass) bypass_d = 1'b0;
    else if (state_q == SH_DR)           bypass_d = tdi_i;
`ifdef JTAG_IDCODE_EN
    idcode_sr_d = idcode_sr_q;
    if (state_q == CAP_DR && sel_idcode) idcode_sr_d = IDCODE_VALUE;
    else if (state_q == SH_DR)           idcode_sr_d = {tdi_i, idcode_sr_q[31:1]};
`endif
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      state_q     <= TLR;
      ir_sr_q     <= '0;
      ir_reg_q    <= RST_INSTR;
      bypass_q    <= 1'b0;
`ifdef JTAG_IDCODE_EN
      idcode_sr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_reg_q    <= ir_reg_d;
      bypass_q    <= bypass_d;
`ifdef JTAG_IDCODE_EN
      idcode_sr_q <= idcode_sr_d;
`endif
    end
  end

  always_comb begin
    dr_bit = bypass_q;
    if (sel_extest || sel_sample) dr_bit = bs_chain_tdi_i;
    else if (sel_mbist)           dr_bit = mbist_tdi_i;
    else if (sel_debug)           dr_bit = debug_tdi_i;
`ifdef JTAG_IDCODE_EN
    else if (sel_idcode)          dr_bit = idcode_sr_q[0];
`endif
  end

  // Strobes stay unregistered: downstream registers act on the edge leaving each state.
  always_comb begin
    tdo_o = 1'b0;
    if (state_q == SH_IR)      tdo_o = ir_sr_q[0];
    else if (state_q == SH_DR) tdo_o = dr_bit;
  end

  assign tdo_oe_o                = (state_q == SH_IR) || (state_q == SH_DR);
  assign test_logic_reset_o      = (state_q == TLR);
  assign capture_dr_o            = (state_q == CAP_DR);
  assign shift_dr_o              = (state_q == SH_DR);
  assign pause_dr_o              = (state_q == PAU_DR);
  assign update_dr_o             = (state_q == UPD_DR);
  assign extest_select_o         = sel_extest;
  assign sample_preload_select_o = sel_sample;
  assign mbist_select_o          = sel_mbist;
  assign debug_select_o          = sel_debug;

endmodule
